// File: rtl/spi_pkg.sv
// Shared constants and width helpers for the SPI FIFO slice.
package spi_pkg;

  localparam int SPI_FIFO_DEPTH = 8;
  localparam int SPI_FIFO_WIDTH = 8;

  // LEVEL must represent 0..DEPTH inclusive, hence one bit wider than a pointer
  function automatic int spi_lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [$clog2(SPI_FIFO_DEPTH):0]   spi_level_t;
  typedef logic [$clog2(SPI_FIFO_DEPTH)-1:0] spi_ptr_t;

endpackage

// File: rtl/spi_fifo_if.sv
// Producer/consumer and status bundle of one SPI FIFO instance (RX or TX).
interface spi_fifo_if
  import spi_pkg::*;
#(
  parameter int DEPTH = SPI_FIFO_DEPTH,
  parameter int WIDTH = SPI_FIFO_WIDTH
) ();

  localparam int LW = $clog2(DEPTH) + 1;

  logic             WR_EN;
  logic [WIDTH-1:0] WR_DATA;
  logic             RD_EN;
  logic [WIDTH-1:0] RD_DATA;
  logic             FLUSH;
  logic             CLR_ERR;
  logic             FULL;
  logic             EMPTY;
  logic [LW-1:0]    LEVEL;
  logic             OVERRUN;
  logic             UNDERRUN;
  logic [LW-1:0]    THRESHOLD;
  logic             THR_HIT;

  modport master (
    output WR_EN, WR_DATA, RD_EN, FLUSH, CLR_ERR, THRESHOLD,
    input  RD_DATA, FULL, EMPTY, LEVEL, OVERRUN, UNDERRUN, THR_HIT
  );

  modport slave (
    input  WR_EN, WR_DATA, RD_EN, FLUSH, CLR_ERR, THRESHOLD,
    output RD_DATA, FULL, EMPTY, LEVEL, OVERRUN, UNDERRUN, THR_HIT
  );

endinterface

// File: rtl/spi_fifo_mem.sv
// FIFO storage: synchronous-write, asynchronous-read register file, data not reset.
module spi_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     PCLK,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] entries [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge PCLK) begin
        if (we && (waddr == AW'(gi))) begin
          entry_reg <= wdata;
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  assign rdata = entries[raddr];

endmodule

// File: rtl/spi_fifo.sv
// First-word-fall-through FIFO with sticky error flags and optional level watermark.
// Watermark logic is built only when SPI_FIFO_THRESHOLD_EN is defined.
module spi_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = SPI_FIFO_DEPTH,
  parameter int WIDTH = SPI_FIFO_WIDTH
) (
  input logic        PCLK,
  input logic        PRESETn,
  spi_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = spi_lvl_w(DEPTH);

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic [LW-1:0]    level_next;
  logic             full_reg;
  logic             empty_reg;
  logic             overrun_reg;
  logic             underrun_reg;
  logic             do_push;
  logic             do_pop;
  logic             ovr_set;
  logic             und_set;
  logic [WIDTH-1:0] mem_rdata;

  // A push into a full FIFO is legal when a pop frees the head in the same cycle
  always_comb begin
    do_pop     = bus.RD_EN && !empty_reg && !bus.FLUSH;
    do_push    = bus.WR_EN && (!full_reg || bus.RD_EN) && !bus.FLUSH;
    ovr_set    = bus.WR_EN && full_reg && !bus.RD_EN && !bus.FLUSH;
    und_set    = bus.RD_EN && empty_reg && !bus.FLUSH;
    level_next = level_reg;
    if (bus.FLUSH) begin
      level_next = '0;
    end else if (do_push && !do_pop) begin
      level_next = level_reg + LW'(1);
    end else if (do_pop && !do_push) begin
      level_next = level_reg - LW'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overrun_reg  <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      if (bus.FLUSH) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      level_reg    <= level_next;
      full_reg     <= (level_next == LW'(DEPTH));
      empty_reg    <= (level_next == '0);
      // a fresh error wins over a clear in the same cycle
      overrun_reg  <= (overrun_reg  && !bus.CLR_ERR) || ovr_set;
      underrun_reg <= (underrun_reg && !bus.CLR_ERR) || und_set;
    end
  end

  spi_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .PCLK  (PCLK),
    .we    (do_push),
    .waddr (wr_ptr_reg),
    .wdata (bus.WR_DATA),
    .raddr (rd_ptr_reg),
    .rdata (mem_rdata)
  );

  assign bus.RD_DATA  = empty_reg ? '0 : mem_rdata;
  assign bus.LEVEL    = level_reg;
  assign bus.FULL     = full_reg;
  assign bus.EMPTY    = empty_reg;
  assign bus.OVERRUN  = overrun_reg;
  assign bus.UNDERRUN = underrun_reg;

`ifdef SPI_FIFO_THRESHOLD_EN
  logic thr_hit_reg;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      thr_hit_reg <= 1'b0;
    end else begin
      thr_hit_reg <= (bus.THRESHOLD != '0) && (level_next >= bus.THRESHOLD);
    end
  end

  assign bus.THR_HIT = thr_hit_reg;
`else
  logic unused_threshold;

  assign unused_threshold = ^bus.THRESHOLD;
  assign bus.THR_HIT      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_fifo.sv
// Randomised and directed bench for spi_fifo against a queue-based reference model.
module tb_spi_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef SPI_FIFO_THRESHOLD_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif

  logic pclk    = 1'b0;
  logic presetn = 1'b0;

  always #5 pclk = ~pclk;

  spi_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  spi_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_dut (
    .PCLK    (pclk),
    .PRESETn (presetn),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [WIDTH-1:0] q[$];
  bit m_ovr = 1'b0;
  bit m_und = 1'b0;
  bit m_thr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a queue plus the error and watermark rules
  task automatic model_update();
    bit full_now, empty_now, wr, rd;
    if (!presetn) begin
      q.delete();
      m_ovr = 1'b0;
      m_und = 1'b0;
      m_thr = 1'b0;
      return;
    end
    wr        = bus.WR_EN;
    rd        = bus.RD_EN;
    full_now  = (q.size() == DEPTH);
    empty_now = (q.size() == 0);
    if (bus.CLR_ERR) begin
      m_ovr = 1'b0;
      m_und = 1'b0;
    end
    if (bus.FLUSH) begin
      q.delete();
    end else begin
      if (wr && full_now && !rd) m_ovr = 1'b1;
      if (rd && empty_now)       m_und = 1'b1;
      if (rd && !empty_now)      void'(q.pop_front());
      if (wr && (!full_now || rd)) q.push_back(bus.WR_DATA);
    end
    m_thr = THR_EN && (bus.THRESHOLD != 0) && (q.size() >= int'(bus.THRESHOLD));
  endtask

  task automatic step(input bit wr, input logic [WIDTH-1:0] d, input bit rd,
                      input bit fl, input bit clr);
    bus.WR_EN   = wr;
    bus.WR_DATA = d;
    bus.RD_EN   = rd;
    bus.FLUSH   = fl;
    bus.CLR_ERR = clr;
    @(posedge pclk);
    model_update();
    #1;
    bus.WR_EN   = 1'b0;
    bus.RD_EN   = 1'b0;
    bus.FLUSH   = 1'b0;
    bus.CLR_ERR = 1'b0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  always @(negedge pclk) begin
    if (chk_en) begin
      check("rd_data",  32'(bus.RD_DATA),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
      check("level",    32'(bus.LEVEL),    32'(q.size()));
      check("full",     32'(bus.FULL),     32'(q.size() == DEPTH));
      check("empty",    32'(bus.EMPTY),    32'(q.size() == 0));
      check("overrun",  32'(bus.OVERRUN),  32'(m_ovr));
      check("underrun", 32'(bus.UNDERRUN), 32'(m_und));
      check("thr_hit",  32'(bus.THR_HIT),  32'(m_thr));
    end
  end

  initial begin
    int p_wr;
    bus.WR_EN     = 1'b0;
    bus.WR_DATA   = '0;
    bus.RD_EN     = 1'b0;
    bus.FLUSH     = 1'b0;
    bus.CLR_ERR   = 1'b0;
    bus.THRESHOLD = '0;

    // reset dominates a concurrent push
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    check("rst_level", 32'(bus.LEVEL), 32'd0);
    check("rst_empty", 32'(bus.EMPTY), 32'd1);
    check("rst_full",  32'(bus.FULL),  32'd0);
    presetn = 1'b1;

    push(8'hA5);
    check("fwft_data",  32'(bus.RD_DATA), 32'hA5);
    check("fwft_level", 32'(bus.LEVEL),   32'd1);
    check("fwft_empty", 32'(bus.EMPTY),   32'd0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    for (int i = 1; i <= 8; i++) push(8'(i));
    push(8'hFF);
    check("ovf_full",    32'(bus.FULL),    32'd1);
    check("ovf_overrun", 32'(bus.OVERRUN), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check("ovf_order", 32'(bus.RD_DATA), 32'(i));
      pop();
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    for (int i = 1; i <= 8; i++) push(8'(i));
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check("fullrw_head",    32'(bus.RD_DATA), 32'h02);
    check("fullrw_level",   32'(bus.LEVEL),   32'd8);
    check("fullrw_overrun", 32'(bus.OVERRUN), 32'd0);
    for (int i = 2; i <= 8; i++) begin
      check("fullrw_order", 32'(bus.RD_DATA), 32'(i));
      pop();
    end
    check("fullrw_last", 32'(bus.RD_DATA), 32'h55);
    pop();

    pop();
    check("udf_set", 32'(bus.UNDERRUN), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("udf_clr", 32'(bus.UNDERRUN), 32'd0);
    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    check("emptyrw_level", 32'(bus.LEVEL),    32'd1);
    check("emptyrw_data",  32'(bus.RD_DATA),  32'h3C);
    check("emptyrw_udf",   32'(bus.UNDERRUN), 32'd1);
    pop();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) push(8'(8'h90 + i));
    check("flush_pre", 32'(bus.LEVEL), 32'd5);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    check("flush_level", 32'(bus.LEVEL),   32'd0);
    check("flush_empty", 32'(bus.EMPTY),   32'd1);
    check("flush_data",  32'(bus.RD_DATA), 32'd0);

    bus.THRESHOLD = LW'(4);
    for (int i = 0; i < 3; i++) push(8'(8'hC0 + i));
    check("thr_below", 32'(bus.THR_HIT), 32'd0);
    push(8'hC3);
    check("thr_hit", 32'(bus.THR_HIT), 32'(THR_EN));
    pop();
    check("thr_drop", 32'(bus.THR_HIT), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // random traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 3000; i++) begin
      p_wr = ((i / 150) % 2 == 0) ? 70 : 30;
      if ($urandom_range(0, 49) == 0) bus.THRESHOLD = LW'($urandom_range(0, DEPTH));
      presetn = ($urandom_range(0, 299) != 0);
      step($urandom_range(0, 99) < p_wr, 8'($urandom), $urandom_range(0, 99) >= p_wr - 15,
           $urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0);
      presetn = 1'b1;
    end

    @(negedge pclk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_fifo.md
SPI_FIFO -- requirements
Module: spi_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of entries (power of two, 2..64).
REQ-002 SHALL have parameter WIDTH, default 8, meaning the entry width in bits.
REQ-003 SHALL have port PCLK, input, 1 bit, the only clock.
REQ-004 SHALL have port PRESETn, input, 1 bit: reset is synchronous and active-low.
REQ-005 SHALL have port WR_EN, input, 1 bit: push request, single-cycle pulse (e.g. slave FIFO_EN[1]).
REQ-006 SHALL have port WR_DATA, input, WIDTH bits: data pushed (e.g. slave RX_REG).
REQ-007 SHALL have port RD_EN, input, 1 bit: pop request, single-cycle pulse (e.g. slave FIFO_EN[0]).
REQ-008 SHALL have port RD_DATA, output, WIDTH bits: head entry, first-word-fall-through.
REQ-009 SHALL have port FLUSH, input, 1 bit: empties the FIFO.
REQ-010 SHALL have port CLR_ERR, input, 1 bit: clears sticky error flags.
REQ-011 SHALL have ports FULL and EMPTY, each output, 1 bit: occupancy status.
REQ-012 SHALL have port LEVEL, output, $clog2(DEPTH)+1 bits: occupancy count, 0..DEPTH.
REQ-013 SHALL have ports OVERRUN and UNDERRUN, each output, 1 bit: sticky error flags.
REQ-014 SHALL have port THRESHOLD, input, $clog2(DEPTH)+1 bits: level watermark.
REQ-015 SHALL have port THR_HIT, output, 1 bit: watermark reached.

Function
REQ-016 SHALL accept a push on a PCLK edge with WR_EN=1 and FULL=0; WR_DATA is written at the write pointer, which increments modulo DEPTH.
REQ-017 SHALL accept a pop on a PCLK edge with RD_EN=1 and EMPTY=0; the read pointer increments modulo DEPTH.
REQ-018 SHALL drive RD_DATA combinationally from the head entry; a pushed word is visible on RD_DATA one cycle after the push into an empty FIFO; RD_DATA is 0 while EMPTY=1.
REQ-019 SHALL keep LEVEL, FULL (LEVEL==DEPTH) and EMPTY (LEVEL==0) registered; they update in the same cycle as the pointers.
REQ-020 SHALL handle WR_EN=1 and RD_EN=1 with FULL=1 as pop and push together: LEVEL stays DEPTH and no OVERRUN is raised.
REQ-021 SHALL handle WR_EN=1 and RD_EN=1 with EMPTY=1 as push only: LEVEL becomes 1 and UNDERRUN is set.
REQ-022 SHALL handle a non-empty, non-full FIFO with both WR_EN and RD_EN asserted as both operations, with LEVEL unchanged.
REQ-023 SHALL ignore WR_EN when FULL=1 and RD_EN=0, set OVERRUN, and leave the stored data untouched.
REQ-024 SHALL ignore RD_EN when EMPTY=1 and set UNDERRUN.
REQ-025 SHALL give FLUSH priority over push and pop in the same cycle: pointers and LEVEL go to 0 and data is discarded; the error flags are unaffected.
REQ-026 SHALL keep OVERRUN and UNDERRUN set until a CLR_ERR cycle clears them; if a new error occurs in the same cycle as CLR_ERR, the flag stays set.
REQ-027 SHALL implement pointers as $clog2(DEPTH) bits with natural wrap; LEVEL SHALL never exceed DEPTH or go below 0.

Reset
REQ-028 SHALL, on a PCLK edge with PRESETn=0, zero both pointers, set LEVEL=0, FULL=0, EMPTY=1, OVERRUN=0, UNDERRUN=0 and THR_HIT=0.
REQ-029 SHALL give reset priority over FLUSH, WR_EN and RD_EN; a reset mid-operation discards all entries, and storage contents need not be cleared.

Configuration
REQ-030 SHALL, with SPI_FIFO_THRESHOLD_EN defined, register THR_HIT=1 when the next LEVEL is >= THRESHOLD and THRESHOLD != 0, otherwise 0, updated with LEVEL.
REQ-031 SHALL, without SPI_FIFO_THRESHOLD_EN, tie THR_HIT to 0, ignore THRESHOLD, and add no threshold comparator logic.

Structure
REQ-032 SHALL take the default DEPTH and WIDTH constants, and a typedef for the level/pointer width helper, from the shared package spi_pkg.
REQ-033 SHALL place the storage array in one sub-module, spi_fifo_mem: a synchronous-write, asynchronous-read register file with no reset on the data.
REQ-034 SHALL be used as two instances by the SPI top: one RX (push from the slave, pop from APB) and one TX (push from APB, pop from the slave).

Verification
REQ-035 SHALL cover: reset, push 0xA5 -> next cycle RD_DATA=0xA5, LEVEL=1, EMPTY=0.
REQ-036 SHALL cover: 8 pushes 0x01..0x08, then a 9th push 0xFF -> FULL=1, OVERRUN=1, and 8 pops return 0x01..0x08 in order.
REQ-037 SHALL cover: FULL, then simultaneous push 0x55 and pop -> head advances, LEVEL=8, OVERRUN=0, and 0x55 is popped last.
REQ-038 SHALL cover: empty FIFO, pop -> UNDERRUN=1; then CLR_ERR -> UNDERRUN=0; then simultaneous push 0x3C and pop -> LEVEL=1, RD_DATA=0x3C, UNDERRUN=1.
REQ-039 SHALL cover: LEVEL=5, FLUSH together with a push -> LEVEL=0, EMPTY=1, and the push is dropped.
REQ-040 SHALL cover: SPI_FIFO_THRESHOLD_EN defined, THRESHOLD=4, 4 pushes -> THR_HIT rises with LEVEL=4; one pop -> THR_HIT=0.
